// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: memory arbiter states and grant identifiers.
// The hazard unit reuses the same encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccIf = 2'd1,
    StAccDm = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int unsigned CNT_W = 4;

  // DM wins unless it was the previous grant and IF is also pending.
  function automatic logic pick_dm(input logic if_pend, input logic dm_pend,
                                   input logic last_grant);
    return dm_pend & (~if_pend | (last_grant == GNT_IF));
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable wait-state down-counter; zero flags the last memory cycle of an access.
module mem_wait_counter
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, sequencing each
// access over MEM_LAT cycles and returning registered data with a one-cycle ready.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              if_pend, dm_pend;

  mem_wait_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .zero(cnt_zero)
  );

  // A port whose ready is high this cycle has just been served and is masked.
  assign if_pend = if_req & ~if_ready_q;
  assign dm_pend = dm_req & ~dm_ready_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (pick_dm(if_pend, dm_pend, last_grant_q)) begin
          state_d      = StAccDm;
          addr_d       = dm_addr;
          wdata_d      = dm_wdata;
          we_d         = dm_we;
          last_grant_d = GNT_DM;
          cnt_load     = 1'b1;
        end else if (if_pend) begin
          state_d      = StAccIf;
          addr_d       = if_addr;
          wdata_d      = '0;
          we_d         = 1'b0;
          last_grant_d = GNT_IF;
          cnt_load     = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StAccIf: begin
        if (cnt_zero) begin
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          state_d    = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StAccDm: begin
        if (cnt_zero) begin
          if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          dm_ready_d = 1'b1;
          state_d    = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GNT_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
    end
  end

  // Decoded from state so an asynchronous reset drops the enable immediately.
  assign mem_en    = (state_q == StAccIf) || (state_q == StAccDm);
  assign mem_we    = (state_q == StAccDm) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15) against a word-array
// memory and a transaction-level reference of latency, grant order and returned data.
module tb_mem_port_arbiter;

  localparam int N = 3;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic [31:0] if_rdata  [N];
  logic        if_ready  [N];
  logic        dm_req    [N];
  logic        dm_we     [N];
  logic [31:0] dm_addr   [N];
  logic [31:0] dm_wdata  [N];
  logic [31:0] dm_rdata  [N];
  logic        dm_ready  [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        stall_if  [N];
  logic        stall_mem [N];

  logic [31:0] mem     [N][256];
  logic [31:0] ref_mem [N][256];
  logic [31:0] exp_if  [N];
  logic [31:0] exp_dm  [N];
  logic        mem_clr;
  logic        poke_en;
  int          poke_i;
  logic [7:0]  poke_w;
  logic [31:0] poke_d;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(L)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_ready (if_ready[g]),
      .dm_req   (dm_req[g]),
      .dm_we    (dm_we[g]),
      .dm_addr  (dm_addr[g]),
      .dm_wdata (dm_wdata[g]),
      .dm_rdata (dm_rdata[g]),
      .dm_ready (dm_ready[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .stall_if (stall_if[g]),
      .stall_mem(stall_mem[g])
    );
    assign mem_rdata[g] = mem[g][mem_addr[g][9:2]];
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++)
        for (int w = 0; w < 256; w++) mem[i][w] <= '0;
    end else begin
      if (poke_en) mem[poke_i][poke_w] <= poke_d;
      for (int i = 0; i < N; i++)
        if (mem_en[i] && mem_we[i]) mem[i][mem_addr[i][9:2]] <= mem_wdata[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int i, input logic [7:0] w, input logic [31:0] d);
    poke_en = 1'b1;
    poke_i  = i;
    poke_w  = w;
    poke_d  = d;
    tick();
    poke_en = 1'b0;
    ref_mem[i][w] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_if[i] = '0;
      exp_dm[i] = '0;
    end
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    mem_clr = 1'b1;
    poke_en = 1'b0;
    poke_i  = 0;
    poke_w  = '0;
    poke_d  = '0;
    for (int i = 0; i < N; i++) begin
      if_req[i] = 1'b0;  if_addr[i] = '0;
      dm_req[i] = 1'b0;  dm_we[i] = 1'b0;  dm_addr[i] = '0;  dm_wdata[i] = '0;
      exp_if[i] = '0;    exp_dm[i] = '0;
      for (int w = 0; w < 256; w++) ref_mem[i][w] = '0;
    end
    tick();
    mem_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({if_rdata[i], dm_rdata[i], if_ready[i], dm_ready[i], mem_en[i], mem_we[i],
           mem_addr[i], mem_wdata[i], stall_if[i], stall_mem[i]} !== '0)
        $display("FAIL reset_state[%0d]: got if_rdata=%h dm_rdata=%h rdy=%b%b en=%b we=%b addr=%h wdata=%h, want all zero",
                 i, if_rdata[i], dm_rdata[i], if_ready[i], dm_ready[i], mem_en[i], mem_we[i],
                 mem_addr[i], mem_wdata[i]);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
  endtask

  // One isolated access from idle; checks latency, enable window, address, data, stall.
  task automatic run_access(input int i, input bit dm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input string name);
    int lat = lat_of(i);
    int edges = 0, en_cnt = 0, we_cnt = 0;
    bit addr_ok = 1, stall_ok = 1, done = 0, rdy;
    logic [31:0] expd = ref_mem[i][addr[9:2]];
    if (dm) begin
      dm_req[i] = 1'b1; dm_we[i] = we; dm_addr[i] = addr; dm_wdata[i] = wdata;
    end else begin
      if_req[i] = 1'b1; if_addr[i] = addr;
    end
    #1;
    if ((dm ? stall_mem[i] : stall_if[i]) !== 1'b1) stall_ok = 0;
    while (!done && edges < 40) begin
      tick();
      edges++;
      rdy = dm ? dm_ready[i] : if_ready[i];
      if (mem_en[i] === 1'b1) begin
        en_cnt++;
        if (mem_addr[i] !== addr) addr_ok = 0;
      end
      if (mem_we[i] === 1'b1) we_cnt++;
      if ((dm ? stall_mem[i] : stall_if[i]) !== !rdy) stall_ok = 0;
      if (rdy) done = 1;
    end
    if (!dm) exp_if[i] = expd;
    else if (!we) exp_dm[i] = expd;
    else ref_mem[i][addr[9:2]] = wdata;

    n_checks++;
    if (edges != lat + 1 || !done)
      $display("FAIL %s_latency[%0d]: got %0d cycles (done=%0d), want %0d", name, i, edges, done, lat + 1);
    else n_pass++;
    n_checks++;
    if (en_cnt != lat) $display("FAIL %s_mem_en[%0d]: got %0d cycles, want %0d", name, i, en_cnt, lat);
    else n_pass++;
    n_checks++;
    if (we_cnt != (we ? lat : 0))
      $display("FAIL %s_mem_we[%0d]: got %0d cycles, want %0d", name, i, we_cnt, we ? lat : 0);
    else n_pass++;
    n_checks++;
    if (!addr_ok || !stall_ok)
      $display("FAIL %s_addr_stall[%0d]: got addr_ok=%0d stall_ok=%0d, want 1 1", name, i, addr_ok, stall_ok);
    else n_pass++;
    n_checks++;
    if (if_rdata[i] !== exp_if[i] || dm_rdata[i] !== exp_dm[i])
      $display("FAIL %s_rdata[%0d]: got if=%h dm=%h, want if=%h dm=%h", name, i,
               if_rdata[i], dm_rdata[i], exp_if[i], exp_dm[i]);
    else n_pass++;

    if_req[i] = 1'b0;
    dm_req[i] = 1'b0;
    tick();
    n_checks++;
    if (if_ready[i] !== 1'b0 || dm_ready[i] !== 1'b0 || mem_en[i] !== 1'b0)
      $display("FAIL %s_ready_pulse[%0d]: got rdy=%b%b en=%b after pulse, want 000", name, i,
               if_ready[i], dm_ready[i], mem_en[i]);
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    poke(0, 8'd1, 32'h2008_0005);
    run_access(0, 1'b0, 1'b0, 32'h0000_0004, '0, "fetch");
  endtask

  task automatic test_simultaneous();
    int lat = lat_of(0);
    int edges = 0, dm_at = -1, if_at = -1;
    poke(0, 8'd4, 32'h1111_2222);
    poke(0, 8'd64, 32'hDEAD_BEEF);
    pulse_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h100;
    while (if_at < 0 && edges < 40) begin
      tick();
      edges++;
      if (dm_ready[0] === 1'b1 && dm_at < 0) begin
        dm_at = edges;
        dm_req[0] = 1'b0;
        n_checks++;
        if (dm_rdata[0] !== 32'hDEAD_BEEF)
          $display("FAIL simul_dm_rdata: got %h, want %h", dm_rdata[0], 32'hDEAD_BEEF);
        else n_pass++;
      end
      if (if_ready[0] === 1'b1) begin
        if_at = edges;
        if_req[0] = 1'b0;
        n_checks++;
        if (if_rdata[0] !== 32'h1111_2222)
          $display("FAIL simul_if_rdata: got %h, want %h", if_rdata[0], 32'h1111_2222);
        else n_pass++;
      end
    end
    exp_dm[0] = 32'hDEAD_BEEF;
    exp_if[0] = 32'h1111_2222;
    n_checks++;
    if (dm_at != lat + 1 || if_at != 2 * (lat + 1))
      $display("FAIL simul_order: got dm_ready@%0d if_ready@%0d, want dm@%0d if@%0d",
               dm_at, if_at, lat + 1, 2 * (lat + 1));
    else n_pass++;
    tick();
  endtask

  task automatic test_store_load();
    run_access(0, 1'b1, 1'b1, 32'h200, 32'h1234_5678, "store");
    run_access(0, 1'b1, 1'b0, 32'h200, '0, "load");
  endtask

  task automatic test_back_to_back();
    int lat = lat_of(0);
    int edges = 0, last_at = 0, got = 0, bad_order = 0, bad_gap = 0, bad_data = 0;
    bit want_dm = 1;
    pulse_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h100;
    while (got < 8 && edges < 200) begin
      tick();
      edges++;
      if (if_ready[0] === 1'b1 || dm_ready[0] === 1'b1) begin
        if (dm_ready[0] !== want_dm || if_ready[0] !== !want_dm) bad_order++;
        if (edges - last_at != lat + 1) bad_gap++;
        if (want_dm && dm_rdata[0] !== ref_mem[0][64]) bad_data++;
        if (!want_dm && if_rdata[0] !== ref_mem[0][4]) bad_data++;
        last_at = edges;
        want_dm = !want_dm;
        got++;
      end
    end
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    exp_dm[0] = ref_mem[0][64];
    exp_if[0] = ref_mem[0][4];
    n_checks++;
    if (got != 8) $display("FAIL b2b_count: got %0d accesses, want 8", got);
    else n_pass++;
    n_checks++;
    if (bad_order != 0) $display("FAIL b2b_alternate: got %0d out-of-order grants, want 0", bad_order);
    else n_pass++;
    n_checks++;
    if (bad_gap != 0) $display("FAIL b2b_throughput: got %0d bad spacings, want 0", bad_gap);
    else n_pass++;
    n_checks++;
    if (bad_data != 0) $display("FAIL b2b_data: got %0d bad words, want 0", bad_data);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    bit saw_ready = 0;
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h300; dm_wdata[0] = $urandom;
    tick();
    tick();
    n_checks++;
    if (mem_en[0] !== 1'b1) $display("FAIL abort_setup: got mem_en=%b, want 1", mem_en[0]);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_en[0] !== 1'b0 || mem_we[0] !== 1'b0)
      $display("FAIL abort_async: got mem_en=%b mem_we=%b, want 0 0", mem_en[0], mem_we[0]);
    else n_pass++;
    dm_req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dm_ready[0] !== 1'b0) saw_ready = 1;
    end
    n_checks++;
    if (saw_ready || {if_rdata[0], dm_rdata[0], if_ready[0], mem_addr[0], mem_wdata[0]} !== '0)
      $display("FAIL abort_outputs: got ready_seen=%0d if_rdata=%h dm_rdata=%h addr=%h wdata=%h, want all zero",
               saw_ready, if_rdata[0], dm_rdata[0], mem_addr[0], mem_wdata[0]);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_if[i] = '0;
      exp_dm[i] = '0;
    end
    tick();
    poke(0, 8'hC0, 32'hCAFE_F00D);
    run_access(0, 1'b1, 1'b0, 32'h300, '0, "post_abort_load");
  endtask

  task automatic test_latency_extremes();
    poke(1, 8'd7, 32'hA5A5_0001);
    poke(2, 8'd9, 32'h5A5A_0002);
    run_access(1, 1'b0, 1'b0, 32'h1C, '0, "lat1_fetch");
    run_access(2, 1'b1, 1'b0, 32'h24, '0, "lat15_load");
    run_access(2, 1'b0, 1'b0, 32'h24, '0, "lat15_fetch");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int i = $urandom_range(0, N - 1);
      bit dm = 1'($urandom_range(0, 1));
      bit we = dm && ($urandom_range(0, 2) == 0);
      logic [31:0] a = {22'($urandom), 8'($urandom), 2'b00};
      run_access(i, dm, we, a, $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store_load();
    test_back_to_back();
    test_reset_mid_access();
    test_latency_extremes();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
